// File: rtl/mult_bcd_converter.sv
// Sequential double-dabble converter: signed product in, sign plus packed BCD magnitude out.
// One magnitude bit is shifted into the BCD scratch per clock; the result commits after WIDTH shifts.
module mult_bcd_converter #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      mult_in,
  output logic                  busy,
  output logic                  bcd_valid,
  output logic                  sign,
  output logic [4*DIGITS-1:0]   bcd
);

  // state   | meaning
  // IDLE    | waiting for start; last result (if any) still presented
  // SHIFT   | add-3 / shift loop, one magnitude bit per clock
  // DONE    | result committed; wait for start to drop before rearming
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  logic [1:0]       state_q,   state_d;
  logic [BW-1:0]    scratch_q, scratch_d;
  logic [WIDTH-1:0] mag_q,     mag_d;
  logic [CW-1:0]    cnt_q,     cnt_d;
  logic             sign_r_q,  sign_r_d;
  logic             sign_q,    sign_d;
  logic [BW-1:0]    bcd_q,     bcd_d;
  logic             busy_q,    busy_d;
  logic             valid_q,   valid_d;

  logic [BW-1:0]    adjusted;
  logic [3:0]       digit;
  logic [BW-1:0]    shifted_bcd;
  logic [WIDTH-1:0] shifted_mag;

  // Digits >= 5 get +3 so that the following doubling carries correctly into the next decade.
  always_comb begin
    adjusted = '0;
    digit    = '0;
    for (int i = 0; i < DIGITS; i++) begin
      digit = scratch_q[4*i +: 4];
      adjusted[4*i +: 4] = (digit >= 4'd5) ? (digit + 4'd3) : digit;
    end
    {shifted_bcd, shifted_mag} = {adjusted[BW-2:0], mag_q, 1'b0};
  end

  always_comb begin
    state_d   = state_q;
    scratch_d = scratch_q;
    mag_d     = mag_q;
    cnt_d     = cnt_q;
    sign_r_d  = sign_r_q;
    sign_d    = sign_q;
    bcd_d     = bcd_q;
    busy_d    = busy_q;
    valid_d   = valid_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          sign_r_d  = mult_in[WIDTH-1];
          // The most negative input negates to itself, which reads correctly as unsigned 2^(WIDTH-1).
          mag_d     = mult_in[WIDTH-1] ? (~mult_in + 1'b1) : mult_in;
          scratch_d = '0;
          cnt_d     = '0;
          busy_d    = 1'b1;
          valid_d   = 1'b0;
          state_d   = S_SHIFT;
        end
      end

      S_SHIFT: begin
        scratch_d = shifted_bcd;
        mag_d     = shifted_mag;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          bcd_d   = shifted_bcd;
          sign_d  = sign_r_q;
          busy_d  = 1'b0;
          valid_d = 1'b1;
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        // A level-held request must drop before another conversion is accepted.
        if (!start) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      scratch_q <= '0;
      mag_q     <= '0;
      cnt_q     <= '0;
      sign_r_q  <= 1'b0;
      sign_q    <= 1'b0;
      bcd_q     <= '0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      scratch_q <= scratch_d;
      mag_q     <= mag_d;
      cnt_q     <= cnt_d;
      sign_r_q  <= sign_r_d;
      sign_q    <= sign_d;
      bcd_q     <= bcd_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
    end
  end

  assign busy      = busy_q;
  assign bcd_valid = valid_q;
  assign sign      = sign_q;
  assign bcd       = bcd_q;

endmodule

// File: tb/tb_mult_bcd_converter.sv
// Self-checking bench for mult_bcd_converter; expected results come from an integer
// divide-by-ten reference model of the signed product.
module tb_mult_bcd_converter;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] mult_in;
  logic        busy;
  logic        bcd_valid;
  logic        sign;
  logic [19:0] bcd;

  int errors = 0;
  int checks = 0;

  mult_bcd_converter #(.WIDTH(16), .DIGITS(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .mult_in   (mult_in),
    .busy      (busy),
    .bcd_valid (bcd_valid),
    .sign      (sign),
    .bcd       (bcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [19:0] ref_bcd(input logic [15:0] v);
    int m;
    logic [19:0] r;
    m = int'($signed(v));
    if (m < 0) m = -m;
    r = '0;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  function automatic logic ref_sign(input logic [15:0] v);
    return int'($signed(v)) < 0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drops start for a cycle (so DONE can rearm), then requests a conversion of val.
  // lat = edges after the accepting edge until a valid result is seen (-1 on timeout).
  task automatic run_conv(input logic [15:0] val, input bit hold,
                          output int lat, output int busy_cycles);
    int n;
    start = 1'b0;
    step();
    mult_in = val;
    start   = 1'b1;
    step();
    busy_cycles = busy ? 1 : 0;
    if (!hold) start = 1'b0;
    lat = -1;
    n = 0;
    while (n < 40) begin
      step();
      n++;
      if (busy) busy_cycles++;
      if (bcd_valid && !busy) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    mult_in = '0;
    step();
    step();
    reset = 1'b0;
    step();
    checks++;
    if (busy !== 1'b0 || bcd_valid !== 1'b0 || sign !== 1'b0 || bcd !== 20'h0) begin
      errors++;
      $display("FAIL reset_state: busy=%b valid=%b sign=%b bcd=%h, required 0/0/0/00000",
               busy, bcd_valid, sign, bcd);
    end
  endtask

  task automatic test_held_start();
    int lat, bc, extra_busy;
    logic [15:0] v;
    v = 16'd3195;
    run_conv(v, 1'b1, lat, bc);
    checks++;
    if (bcd !== ref_bcd(v) || sign !== ref_sign(v) || lat !== 16) begin
      errors++;
      $display("FAIL held_3195: bcd=%h sign=%b lat=%0d, required %h %b 16",
               bcd, sign, lat, ref_bcd(v), ref_sign(v));
    end
    extra_busy = 0;
    mult_in = 16'd1234;
    for (int i = 0; i < 20; i++) begin
      step();
      if (busy || !bcd_valid) extra_busy++;
    end
    checks++;
    if (extra_busy !== 0 || bcd !== 20'h03195) begin
      errors++;
      $display("FAIL no_retrigger: bad_cycles=%0d bcd=%h, required 0 03195", extra_busy, bcd);
    end
  endtask

  task automatic test_negative();
    int lat, bc;
    logic [15:0] v;
    v = 16'(-4002);
    run_conv(v, 1'b1, lat, bc);
    checks++;
    if (bcd !== 20'h04002 || sign !== 1'b1) begin
      errors++;
      $display("FAIL neg_4002: bcd=%h sign=%b, required 04002 1", bcd, sign);
    end
    checks++;
    if (bc !== 16) begin
      errors++;
      $display("FAIL busy_len: busy cycles=%0d, required 16", bc);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    run_conv(16'd9603, 1'b1, lat, bc);
    checks++;
    if (bcd !== 20'h09603 || sign !== 1'b0) begin
      errors++;
      $display("FAIL b2b_9603: bcd=%h sign=%b, required 09603 0", bcd, sign);
    end
    start = 1'b0;
    step();
    step();
    checks++;
    if (bcd_valid !== 1'b1 || bcd !== 20'h09603) begin
      errors++;
      $display("FAIL idle_hold: valid=%b bcd=%h, required 1 09603", bcd_valid, bcd);
    end
    run_conv(16'd0, 1'b0, lat, bc);
    checks++;
    if (bcd !== 20'h00000 || sign !== 1'b0 || lat !== 16) begin
      errors++;
      $display("FAIL zero_pulse: bcd=%h sign=%b lat=%0d, required 00000 0 16", bcd, sign, lat);
    end
  endtask

  task automatic test_boundary();
    int lat, bc;
    run_conv(16'h8000, 1'b1, lat, bc);
    checks++;
    if (bcd !== 20'h32768 || sign !== 1'b1) begin
      errors++;
      $display("FAIL min_neg: bcd=%h sign=%b, required 32768 1", bcd, sign);
    end
    run_conv(16'h7FFF, 1'b1, lat, bc);
    checks++;
    if (bcd !== 20'h32767 || sign !== 1'b0) begin
      errors++;
      $display("FAIL max_pos: bcd=%h sign=%b, required 32767 0", bcd, sign);
    end
    run_conv(16'hFFFF, 1'b1, lat, bc);
    checks++;
    if (bcd !== 20'h00001 || sign !== 1'b1) begin
      errors++;
      $display("FAIL minus_one: bcd=%h sign=%b, required 00001 1", bcd, sign);
    end
  endtask

  task automatic test_mid_reset();
    int lat, bc;
    start = 1'b0;
    step();
    mult_in = 16'd12345;
    start = 1'b1;
    step();
    for (int i = 0; i < 8; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    start = 1'b0;
    checks++;
    if (busy !== 1'b0 || bcd_valid !== 1'b0 || bcd !== 20'h0 || sign !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: busy=%b valid=%b sign=%b bcd=%h, required 0/0/0/00000",
               busy, bcd_valid, sign, bcd);
    end
    run_conv(16'd16384, 1'b1, lat, bc);
    checks++;
    if (bcd !== 20'h16384 || sign !== 1'b0 || lat !== 16) begin
      errors++;
      $display("FAIL after_reset: bcd=%h sign=%b lat=%0d, required 16384 0 16", bcd, sign, lat);
    end
  endtask

  task automatic test_ignore_inputs();
    logic [15:0] v;
    int n, lat;
    for (int t = 0; t < 3; t++) begin
      v = 16'($urandom);
      start = 1'b0;
      step();
      mult_in = v;
      start = 1'b1;
      step();
      lat = -1;
      n = 0;
      while (n < 40) begin
        mult_in = 16'($urandom);
        start   = 1'($urandom);
        step();
        n++;
        if (bcd_valid && !busy) begin
          lat = n;
          break;
        end
      end
      checks++;
      if (bcd !== ref_bcd(v) || sign !== ref_sign(v) || lat !== 16) begin
        errors++;
        $display("FAIL latched_op %h: bcd=%h sign=%b lat=%0d, required %h %b 16",
                 v, bcd, sign, lat, ref_bcd(v), ref_sign(v));
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] v;
    int lat, bc;
    for (int t = 0; t < 25; t++) begin
      v = 16'($urandom);
      run_conv(v, 1'($urandom), lat, bc);
      checks++;
      if (bcd !== ref_bcd(v) || sign !== ref_sign(v) || lat !== 16 || bc !== 16) begin
        errors++;
        $display("FAIL random %h: bcd=%h sign=%b lat=%0d busy=%0d, required %h %b 16 16",
                 v, bcd, sign, lat, bc, ref_bcd(v), ref_sign(v));
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    mult_in = '0;
    test_reset();
    test_held_start();
    test_negative();
    test_back_to_back();
    test_boundary();
    test_mid_reset();
    test_ignore_inputs();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
